// File: rtl/systolic_sequencer.sv
// systolic_sequencer: load/compute/readout sequencer for a 2x2 output-stationary MAC array.
//
// Buffers matrices A and B (four elements each, index {row,col}) from a byte-wide load port.
// Once all eight elements are present it clears the PEs, feeds the array's left and top edges
// with row/column skew, lets the last MAC settle, and captures the four accumulators. The
// captured results are read back one at a time, saturated to DATA_W bits.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   load_en/load_sel_ab   write in_data into A (0) or B (1) at load_index
//   load_index, in_data   element index {row,col} and element value
//   output_en/output_sel  register result[output_sel] (saturated) onto out_data
//   out_data              selected C element
//   done, busy            results valid / sequence in progress
//   pe_clear, pe_en       PE accumulator clear and advance/MAC enable
//   a_in0/1, b_in0/1      left-edge (rows 0/1) and top-edge (cols 0/1) feeds
//   c00..c11              PE accumulator values
module systolic_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_sel_ab,
    input  logic [1:0]        load_index,
    input  logic [DATA_W-1:0] in_data,
    input  logic              output_en,
    input  logic [1:0]        output_sel,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic              busy,
    output logic              pe_clear,
    output logic              pe_en,
    output logic [DATA_W-1:0] a_in0,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] b_in0,
    output logic [DATA_W-1:0] b_in1,
    input  logic [ACC_W-1:0]  c00,
    input  logic [ACC_W-1:0]  c01,
    input  logic [ACC_W-1:0]  c10,
    input  logic [ACC_W-1:0]  c11
);

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StSettle, StCapture, StDone} state_e;

    localparam logic [ACC_W-1:0] SatMax = (ACC_W'(1) << DATA_W) - ACC_W'(1);

    state_e            state_q;
    logic [1:0]        step_q;
    logic [DATA_W-1:0] a_q [4];
    logic [DATA_W-1:0] b_q [4];
    logic [7:0]        loaded_mask_q;
    logic [ACC_W-1:0]  result_q [4];

    logic              load_ok;
    logic [1:0]        feed_step;
    logic [DATA_W-1:0] nf_a0, nf_a1, nf_b0, nf_b1;

    assign load_ok = load_en && (state_q == StIdle || state_q == StDone);

    // Feeds for the step about to be presented: step 0 when leaving CLEAR, else the next step.
    assign feed_step = (state_q == StClear) ? 2'd0 : step_q + 2'd1;

    always_comb begin
        nf_a0 = '0;
        nf_a1 = '0;
        nf_b0 = '0;
        nf_b1 = '0;
        case (feed_step)
            2'd0: begin
                nf_a0 = a_q[0];
                nf_b0 = b_q[0];
            end
            2'd1: begin
                nf_a0 = a_q[1];
                nf_a1 = a_q[2];
                nf_b0 = b_q[2];
                nf_b1 = b_q[1];
            end
            2'd2: begin
                nf_a1 = a_q[3];
                nf_b1 = b_q[3];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            step_q        <= '0;
            loaded_mask_q <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
            pe_clear      <= 1'b0;
            pe_en         <= 1'b0;
            a_in0         <= '0;
            a_in1         <= '0;
            b_in0         <= '0;
            b_in1         <= '0;
            for (int i = 0; i < 4; i++) begin
                a_q[i]      <= '0;
                b_q[i]      <= '0;
                result_q[i] <= '0;
            end
        end else begin
            if (load_ok) begin
                if (load_sel_ab) b_q[load_index] <= in_data;
                else             a_q[load_index] <= in_data;
                loaded_mask_q[{load_sel_ab, load_index}] <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (loaded_mask_q == 8'hFF) begin
                        state_q  <= StClear;
                        pe_clear <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StClear: begin
                    state_q  <= StFeed;
                    step_q   <= 2'd0;
                    pe_clear <= 1'b0;
                    pe_en    <= 1'b1;
                    a_in0    <= nf_a0;
                    a_in1    <= nf_a1;
                    b_in0    <= nf_b0;
                    b_in1    <= nf_b1;
                end
                StFeed: begin
                    if (step_q == 2'd3) begin
                        state_q <= StSettle;
                        pe_en   <= 1'b0;
                        a_in0   <= '0;
                        a_in1   <= '0;
                        b_in0   <= '0;
                        b_in1   <= '0;
                    end else begin
                        step_q <= step_q + 2'd1;
                        a_in0  <= nf_a0;
                        a_in1  <= nf_a1;
                        b_in0  <= nf_b0;
                        b_in1  <= nf_b1;
                    end
                end
                StSettle: state_q <= StCapture;
                StCapture: begin
                    result_q[0]   <= c00;
                    result_q[1]   <= c01;
                    result_q[2]   <= c10;
                    result_q[3]   <= c11;
                    loaded_mask_q <= '0;
                    state_q       <= StDone;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                end
                StDone: begin
                    // The load itself is performed above; this only leaves DONE.
                    if (load_en) begin
                        state_q <= StIdle;
                        done    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (output_en) begin
            out_data <= (result_q[output_sel] > SatMax) ? '1
                                                        : result_q[output_sel][DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer with a behavioural 2x2 output-stationary PE array attached.
module tb_systolic_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en, load_sel_ab, output_en;
    logic [1:0]  load_index, output_sel;
    logic [7:0]  in_data, out_data;
    logic        done, busy, pe_clear, pe_en;
    logic [7:0]  a_in0, a_in1, b_in0, b_in1;
    logic [16:0] c00, c01, c10, c11;

    int checks = 0;
    int passes = 0;
    logic [7:0] ma [4];
    logic [7:0] mb [4];

    always #5 clk = ~clk;

    systolic_sequencer #(.DATA_W(8), .ACC_W(17)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_sel_ab(load_sel_ab),
        .load_index(load_index), .in_data(in_data), .output_en(output_en),
        .output_sel(output_sel), .out_data(out_data), .done(done), .busy(busy),
        .pe_clear(pe_clear), .pe_en(pe_en), .a_in0(a_in0), .a_in1(a_in1),
        .b_in0(b_in0), .b_in1(b_in1), .c00(c00), .c01(c01), .c10(c10), .c11(c11)
    );

    // PE array: each PE MACs its left/top inputs and forwards them right/down one cycle later.
    logic [7:0] pa0, pa1, pb0, pb1;
    always @(posedge clk or posedge rst) begin
        if (rst || pe_clear) begin
            pa0 <= '0; pa1 <= '0; pb0 <= '0; pb1 <= '0;
            c00 <= '0; c01 <= '0; c10 <= '0; c11 <= '0;
        end else if (pe_en) begin
            c00 <= c00 + 17'(a_in0) * 17'(b_in0);
            c01 <= c01 + 17'(pa0) * 17'(b_in1);
            c10 <= c10 + 17'(a_in1) * 17'(pb0);
            c11 <= c11 + 17'(pa1) * 17'(pb1);
            pa0 <= a_in0; pa1 <= a_in1; pb0 <= b_in0; pb1 <= b_in1;
        end
    end

    // Reference: plain matrix product C = A x B.
    function automatic logic [16:0] exp_c(int sel);
        int i = sel / 2;
        int j = sel % 2;
        int v = int'(ma[i*2]) * int'(mb[j]) + int'(ma[i*2+1]) * int'(mb[2+j]);
        return v[16:0];
    endfunction

    function automatic logic [7:0] sat(logic [16:0] v);
        return (v > 17'd255) ? 8'd255 : v[7:0];
    endfunction

    // All tasks start and end on a negedge.
    task automatic load_one(input int n, input logic [7:0] d);
        load_en = 1'b1; load_sel_ab = (n >= 4); load_index = 2'(n % 4); in_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic load_elem(input int n);
        load_one(n, (n < 4) ? ma[n % 4] : mb[n % 4]);
    endtask

    task automatic load_matrices(input int skip);
        int ord [8];
        for (int i = 0; i < 8; i++) ord[i] = i;
        for (int i = 7; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            int t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < 8; i++) if (ord[i] != skip) load_elem(ord[i]);
    endtask

    task automatic read_out(input logic [1:0] sel, output logic [7:0] v);
        output_en = 1'b1; output_sel = sel;
        @(negedge clk);
        output_en = 1'b0;
        v = out_data;
    endtask

    // Called right after the final load edge E0; checks the state after E1..E8.
    task automatic check_sequence(input string name, input bit inject);
        logic [35:0] exp_v, got_v;
        for (int k = 1; k <= 8; k++) begin
            if (inject && k == 3) begin
                load_en = 1'b1; in_data = 8'd9;
                load_sel_ab = 1'($urandom()); load_index = 2'($urandom());
            end
            @(negedge clk);
            load_en = 1'b0;
            case (k)
                1:       exp_v = {4'b1010, 32'h0};
                2:       exp_v = {4'b0110, ma[0], 8'h0, mb[0], 8'h0};
                3:       exp_v = {4'b0110, ma[1], ma[2], mb[2], mb[1]};
                4:       exp_v = {4'b0110, 8'h0, ma[3], 8'h0, mb[3]};
                5:       exp_v = {4'b0110, 32'h0};
                6, 7:    exp_v = {4'b0010, 32'h0};
                default: exp_v = {4'b0001, 32'h0};
            endcase
            got_v = {pe_clear, pe_en, busy, done, a_in0, a_in1, b_in0, b_in1};
            checks++;
            if (got_v !== exp_v)
                $display("FAIL %s seq E%0d {clr,en,busy,done,a0,a1,b0,b1} got %h want %h",
                         name, k, got_v, exp_v);
            else passes++;
        end
    endtask

    task automatic check_results(input string name);
        logic [7:0]  v;
        logic [67:0] exp_all = {exp_c(0), exp_c(1), exp_c(2), exp_c(3)};
        checks++;
        if ({c00, c01, c10, c11} !== exp_all)
            $display("FAIL %s pe_acc got %h want %h", name, {c00, c01, c10, c11}, exp_all);
        else passes++;
        for (int s = 0; s < 4; s++) begin
            read_out(2'(s), v);
            checks++;
            if (v !== sat(exp_c(s)))
                $display("FAIL %s out_data sel%0d got %0d want %0d", name, s, v, sat(exp_c(s)));
            else passes++;
        end
    endtask

    task automatic check_zero_outs(input string name);
        logic [44:0] got = {out_data, done, busy, pe_clear, pe_en, a_in0, a_in1, b_in0, b_in1};
        checks++;
        if (got !== '0) $display("FAIL %s outputs got %h want 0", name, got);
        else passes++;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        repeat (2) @(negedge clk);
        check_zero_outs("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_zero_outs("reset_released");
        read_out(2'd3, v);
        checks++;
        if (v !== 8'd0) $display("FAIL reset result_reg got %0d want 0", v);
        else passes++;
    endtask

    task automatic test_basic();
        ma = '{8'd1, 8'd2, 8'd3, 8'd4};
        mb = '{8'd5, 8'd6, 8'd7, 8'd8};
        load_matrices(-1);
        check_sequence("basic", 1'b0);
        check_results("basic");
        checks++;
        if ({exp_c(0), exp_c(1), exp_c(2), exp_c(3)} !== {17'd19, 17'd22, 17'd43, 17'd50})
            $display("FAIL basic reference got %0d %0d %0d %0d want 19 22 43 50",
                     exp_c(0), exp_c(1), exp_c(2), exp_c(3));
        else passes++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin ma[i] = 8'd255; mb[i] = 8'd255; end
        load_matrices(-1);
        check_sequence("sat", 1'b0);
        checks++;
        if (c11 !== 17'd130050) $display("FAIL sat c11 got %0d want 130050", c11);
        else passes++;
        check_results("sat");
    endtask

    task automatic test_load_during_feed();
        logic [7:0] v;
        ma = '{8'd1, 8'd2, 8'd3, 8'd4};
        mb = '{8'd5, 8'd6, 8'd7, 8'd8};
        load_matrices(-1);
        check_sequence("feed_load", 1'b1);
        check_results("feed_load");
        checks++;
        if (done !== 1'b1) $display("FAIL done_reload before got %b want 1", done);
        else passes++;
        load_one(0, 8'd2);
        checks++;
        if (done !== 1'b0) $display("FAIL done_reload after got %b want 0", done);
        else passes++;
        for (int s = 0; s < 4; s++) begin
            read_out(2'(s), v);
            checks++;
            if (v !== sat(exp_c(s)))
                $display("FAIL done_reload held sel%0d got %0d want %0d", s, v, sat(exp_c(s)));
            else passes++;
        end
        ma[0] = 8'd2;
    endtask

    task automatic test_reset_mid_feed();
        logic [7:0] v;
        bit         started = 1'b0;
        for (int i = 0; i < 4; i++) begin ma[i] = 8'($urandom()); mb[i] = 8'($urandom()); end
        load_matrices(-1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outs("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || pe_clear || pe_en) started = 1'b1;
        end
        checks++;
        if (started) $display("FAIL reset_mid restart got busy want idle");
        else passes++;
        read_out(2'($urandom()), v);
        checks++;
        if (v !== 8'd0) $display("FAIL reset_mid result got %0d want 0", v);
        else passes++;
        load_matrices(-1);
        check_sequence("reset_reload", 1'b0);
        check_results("reset_reload");
    endtask

    task automatic test_partial_load();
        int  skip = int'($urandom_range(7, 0));
        bit  started = 1'b0;
        for (int i = 0; i < 4; i++) begin ma[i] = 8'($urandom()); mb[i] = 8'($urandom()); end
        load_matrices(skip);
        repeat (20) begin
            @(negedge clk);
            if (busy || pe_clear || pe_en || done) started = 1'b1;
        end
        checks++;
        if (started) $display("FAIL partial idle got activity want idle (skip %0d)", skip);
        else passes++;
        load_elem(skip);
        check_sequence("partial", 1'b0);
        check_results("partial");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin ma[i] = 8'($urandom()); mb[i] = 8'($urandom()); end
            load_matrices(-1);
            check_sequence("random", 1'b0);
            check_results("random");
        end
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_sel_ab = 1'b0; load_index = '0; in_data = '0;
        output_en = 1'b0; output_sel = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_load_during_feed();
        test_reset_mid_feed();
        test_partial_load();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
